// File: rtl/lcd_rx_monitor_if.sv
// Bus bundle between the LCD writer side and the receive monitor.
// master: drives the LCD pins and the readback index, observes the monitor outputs.
// slave : the monitor; samples the LCD pins and the readback index, drives every
//         status/event/readback output.
interface lcd_rx_monitor_if;
    // LCD pins (asynchronous to clk)
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_e;
    logic       lcd_4;
    logic       lcd_5;
    logic       lcd_6;
    logic       lcd_7;
    // Display-buffer readback
    logic [4:0] rd_addr;
    logic [7:0] rd_data;
    // Decode events
    logic       cmd_valid;
    logic [7:0] cmd_byte;
    logic       wr_valid;
    logic [4:0] wr_idx;
    logic [7:0] wr_char;
    // Status
    logic       four_bit;
    logic       disp_on;
    logic       busy;
    logic       proto_err;

    modport master (
        output lcd_rs, lcd_rw, lcd_e, lcd_4, lcd_5, lcd_6, lcd_7, rd_addr,
        input  rd_data, cmd_valid, cmd_byte, wr_valid, wr_idx, wr_char,
               four_bit, disp_on, busy, proto_err
    );

    modport slave (
        input  lcd_rs, lcd_rw, lcd_e, lcd_4, lcd_5, lcd_6, lcd_7, rd_addr,
        output rd_data, cmd_valid, cmd_byte, wr_valid, wr_idx, wr_char,
               four_bit, disp_on, busy, proto_err
    );
endinterface

// File: rtl/lcd_rx_monitor.sv
// Receive-side model of a 4-bit HD44780-style LCD bus. Synchronizes the pins,
// qualifies e strobes, rebuilds bytes from nibbles after the 8-bit/4-bit mode
// switch, decodes instructions and mirrors the 2x16 display RAM.
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   bus        : lcd_rx_monitor_if.slave
//                in : lcd_rs/rw/e/4..7 (async), rd_addr[4:0]
//                out: rd_data[7:0], cmd_valid, cmd_byte[7:0], wr_valid,
//                     wr_idx[4:0], wr_char[7:0], four_bit, disp_on, busy, proto_err
module lcd_rx_monitor #(
    parameter int unsigned MIN_E_HIGH   = 4,
    parameter int unsigned CLEAR_CYCLES = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    lcd_rx_monitor_if.slave bus
);
    localparam int unsigned BUS_W  = 7;
    localparam int unsigned ECNT_W = $clog2(MIN_E_HIGH + 1);
    localparam int unsigned CLR_W  = $clog2(CLEAR_CYCLES + 1);
    localparam int unsigned BUF_N  = 32;
    localparam logic [7:0]  SPACE  = 8'h20;

    typedef enum logic [1:0] {
        ST_INIT8,
        ST_HI,
        ST_LO
    } state_t;

    // Synchronizer and strobe qualification
    logic [BUS_W-1:0]  w_bus_raw;
    logic [BUS_W-1:0]  r_sync1;
    logic [BUS_W-1:0]  r_sync2;
    logic              w_e;
    logic              w_rs;
    logic              w_rw;
    logic [3:0]        w_nib;
    logic              r_e_prev;
    logic [ECNT_W-1:0] r_e_cnt;
    logic              r_stb;
    logic              r_stb_rs;
    logic              r_stb_rw;
    logic [3:0]        r_stb_nib;

    // Decoder state
    state_t            r_state;
    logic [3:0]        r_hi_nib;
    logic              r_hi_rs;
    logic [6:0]        r_addr;
    logic              r_id;
    logic              r_cgram;
    logic [CLR_W-1:0]  r_clr_cnt;
    logic [7:0]        r_buf [BUF_N];

    // Registered outputs
    logic [7:0]        r_rd_data;
    logic              r_cmd_valid;
    logic [7:0]        r_cmd_byte;
    logic              r_wr_valid;
    logic [4:0]        r_wr_idx;
    logic [7:0]        r_wr_char;
    logic              r_four_bit;
    logic              r_disp_on;
    logic              r_busy;
    logic              r_proto_err;

    // Byte assembly helpers
    logic [7:0]        w_byte;
    logic              w_in_win;
    logic [4:0]        w_win_idx;
    logic [6:0]        w_addr_step;

    assign w_bus_raw = {bus.lcd_e, bus.lcd_rs, bus.lcd_rw,
                        bus.lcd_7, bus.lcd_6, bus.lcd_5, bus.lcd_4};
    assign w_e   = r_sync2[6];
    assign w_rs  = r_sync2[5];
    assign w_rw  = r_sync2[4];
    assign w_nib = r_sync2[3:0];

    // Two-flop sync, saturating e-high counter, strobe on qualified falling edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_e_prev  <= 1'b0;
            r_e_cnt   <= '0;
            r_stb     <= 1'b0;
            r_stb_rs  <= 1'b0;
            r_stb_rw  <= 1'b0;
            r_stb_nib <= '0;
        end else begin
            r_sync1  <= w_bus_raw;
            r_sync2  <= r_sync1;
            r_e_prev <= w_e;
            if (w_e) begin
                if (r_e_cnt != ECNT_W'(MIN_E_HIGH)) begin
                    r_e_cnt <= r_e_cnt + ECNT_W'(1);
                end
            end else begin
                r_e_cnt <= '0;
            end
            r_stb     <= r_e_prev && !w_e && (r_e_cnt == ECNT_W'(MIN_E_HIGH));
            r_stb_rs  <= w_rs;
            r_stb_rw  <= w_rw;
            r_stb_nib <= w_nib;
        end
    end

    // Byte value, DDRAM window mapping and address auto-step with line wraps
    always_comb begin
        w_byte    = {r_hi_nib, r_stb_nib};
        w_in_win  = 1'b0;
        w_win_idx = '0;
        if (r_addr[6:4] == 3'b000) begin
            w_in_win  = 1'b1;
            w_win_idx = {1'b0, r_addr[3:0]};
        end else if (r_addr[6:4] == 3'b100) begin
            w_in_win  = 1'b1;
            w_win_idx = {1'b1, r_addr[3:0]};
        end
        if (r_id) begin
            if (r_addr == 7'h27)      w_addr_step = 7'h40;
            else if (r_addr == 7'h67) w_addr_step = 7'h00;
            else                      w_addr_step = r_addr + 7'd1;
        end else begin
            if (r_addr == 7'h00)      w_addr_step = 7'h67;
            else if (r_addr == 7'h40) w_addr_step = 7'h27;
            else                      w_addr_step = r_addr - 7'd1;
        end
    end

    // Mode FSM, instruction decode, display buffer and clear sequencer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_INIT8;
            r_hi_nib    <= '0;
            r_hi_rs     <= 1'b0;
            r_addr      <= '0;
            r_id        <= 1'b1;
            r_cgram     <= 1'b0;
            r_clr_cnt   <= '0;
            r_rd_data   <= SPACE;
            r_cmd_valid <= 1'b0;
            r_cmd_byte  <= '0;
            r_wr_valid  <= 1'b0;
            r_wr_idx    <= '0;
            r_wr_char   <= '0;
            r_four_bit  <= 1'b0;
            r_disp_on   <= 1'b0;
            r_busy      <= 1'b0;
            r_proto_err <= 1'b0;
            for (int i = 0; i < BUF_N; i++) begin
                r_buf[i] <= SPACE;
            end
        end else begin
            r_cmd_valid <= 1'b0;
            r_wr_valid  <= 1'b0;
            // Read sees the pre-write contents on a same-cycle write
            r_rd_data   <= r_buf[bus.rd_addr];

            if (r_busy) begin
                if (32'(r_clr_cnt) < BUF_N) begin
                    r_buf[5'(r_clr_cnt)] <= SPACE;
                end
                if (r_clr_cnt == CLR_W'(CLEAR_CYCLES - 1)) begin
                    r_busy <= 1'b0;
                end
                r_clr_cnt <= r_clr_cnt + CLR_W'(1);
            end

            if (r_stb) begin
                if (r_busy || r_stb_rw) begin
                    r_proto_err <= 1'b1;
                end else begin
                    case (r_state)
                        ST_INIT8: begin
                            if (r_stb_nib == 4'h2) begin
                                r_state    <= ST_HI;
                                r_four_bit <= 1'b1;
                            end else if (r_stb_nib != 4'h3) begin
                                r_proto_err <= 1'b1;
                            end
                        end
                        ST_HI: begin
                            r_hi_nib <= r_stb_nib;
                            r_hi_rs  <= r_stb_rs;
                            r_state  <= ST_LO;
                        end
                        ST_LO: begin
                            r_state <= ST_HI;
                            if (r_stb_rs != r_hi_rs) begin
                                r_proto_err <= 1'b1;
                            end
                            if (!r_hi_rs) begin
                                r_cmd_valid <= 1'b1;
                                r_cmd_byte  <= w_byte;
                                casez (w_byte)
                                    8'b1???????: begin
                                        r_addr  <= w_byte[6:0];
                                        r_cgram <= 1'b0;
                                    end
                                    8'b01??????: r_cgram <= 1'b1;
                                    8'b001?????: begin
                                        // DL=1 drops back to 8-bit mode
                                        if (w_byte[4]) begin
                                            r_state    <= ST_INIT8;
                                            r_four_bit <= 1'b0;
                                        end
                                    end
                                    8'b0001????: ;
                                    8'b00001???: r_disp_on <= w_byte[2];
                                    8'b000001??: r_id <= w_byte[1];
                                    8'b0000001?: r_addr <= '0;
                                    8'b00000001: begin
                                        r_addr    <= '0;
                                        r_id      <= 1'b1;
                                        r_busy    <= 1'b1;
                                        r_clr_cnt <= '0;
                                    end
                                    default: ;
                                endcase
                            end else begin
                                if (w_in_win && !r_cgram) begin
                                    r_buf[w_win_idx] <= w_byte;
                                    r_wr_valid       <= 1'b1;
                                    r_wr_idx         <= w_win_idx;
                                    r_wr_char        <= w_byte;
                                end
                                r_addr <= w_addr_step;
                            end
                        end
                        default: r_state <= ST_INIT8;
                    endcase
                end
            end
        end
    end

    assign bus.rd_data   = r_rd_data;
    assign bus.cmd_valid = r_cmd_valid;
    assign bus.cmd_byte  = r_cmd_byte;
    assign bus.wr_valid  = r_wr_valid;
    assign bus.wr_idx    = r_wr_idx;
    assign bus.wr_char   = r_wr_char;
    assign bus.four_bit  = r_four_bit;
    assign bus.disp_on   = r_disp_on;
    assign bus.busy      = r_busy;
    assign bus.proto_err = r_proto_err;

endmodule

// File: tb/tb_lcd_rx_monitor.sv
// Self-checking bench for lcd_rx_monitor: directed bring-up sequence plus
// randomized nibble traffic compared against a transaction-level LCD model.
module tb_lcd_rx_monitor;
    localparam int unsigned MIN_E_HIGH   = 4;
    localparam int unsigned CLEAR_CYCLES = 32;
    localparam int          PULSE_K      = 4;   // negedge sample after e falls that sees the event
    localparam int          WIN          = 7;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    lcd_rx_monitor_if bus ();

    lcd_rx_monitor #(
        .MIN_E_HIGH   (MIN_E_HIGH),
        .CLEAR_CYCLES (CLEAR_CYCLES)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model (one call per e strobe) ----------------
    logic       m_four, m_have_hi, m_hi_rs, m_id, m_cgram, m_disp, m_err, m_busy;
    logic [3:0] m_hi;
    int         m_addr;
    logic [7:0] m_buf [32];
    logic       e_cmd, e_wr, e_clear;
    logic [7:0] e_cmd_byte, e_wr_char;
    int         e_wr_idx;

    task automatic m_reset();
        m_four = 0; m_have_hi = 0; m_hi_rs = 0; m_hi = 0;
        m_id = 1; m_cgram = 0; m_disp = 0; m_err = 0; m_busy = 0; m_addr = 0;
        for (int i = 0; i < 32; i++) m_buf[i] = 8'h20;
    endtask

    function automatic int win_idx(input int a);
        if (a < 16) return a;
        if (a >= 64 && a < 80) return a - 48;
        return -1;
    endfunction

    task automatic m_strobe(input logic rs, input logic rw, input logic [3:0] nib, input int ehigh);
        logic [7:0] b;
        int idx;
        e_cmd = 0; e_wr = 0; e_clear = 0;
        if (ehigh < int'(MIN_E_HIGH)) return;
        if (m_busy || rw) begin m_err = 1; return; end
        if (!m_four) begin
            if (nib == 4'h2) begin m_four = 1; m_have_hi = 0; end
            else if (nib != 4'h3) m_err = 1;
            return;
        end
        if (!m_have_hi) begin m_hi = nib; m_hi_rs = rs; m_have_hi = 1; return; end
        m_have_hi = 0;
        b = {m_hi, nib};
        if (rs != m_hi_rs) m_err = 1;
        if (!m_hi_rs) begin
            e_cmd = 1; e_cmd_byte = b;
            if (b >= 8'd128)     begin m_addr = int'(b) - 128; m_cgram = 0; end
            else if (b >= 8'd64) m_cgram = 1;
            else if (b >= 8'd32) begin if (b[4]) m_four = 0; end
            else if (b >= 8'd16) ;
            else if (b >= 8'd8)  m_disp = b[2];
            else if (b >= 8'd4)  m_id = b[1];
            else if (b >= 8'd2)  m_addr = 0;
            else if (b == 8'd1) begin
                m_addr = 0; m_id = 1; m_busy = 1; e_clear = 1;
                for (int i = 0; i < 32; i++) m_buf[i] = 8'h20;
            end
        end else begin
            idx = win_idx(m_addr);
            if (idx >= 0 && !m_cgram) begin
                m_buf[idx] = b; e_wr = 1; e_wr_idx = idx; e_wr_char = b;
            end
            if (m_id) m_addr = (m_addr == 39) ? 64 : (m_addr == 103) ? 0 : (m_addr + 1) % 128;
            else      m_addr = (m_addr == 0) ? 103 : (m_addr == 64) ? 39 : m_addr - 1;
        end
    endtask

    // ---------------- busy run-length monitor ----------------
    int busy_run = 0;
    int last_busy_len = 0;
    always @(negedge clk) begin
        if (bus.busy) busy_run <= busy_run + 1;
        else if (busy_run != 0) begin
            last_busy_len <= busy_run;
            busy_run      <= 0;
        end
    end

    logic [7:0] last_rd4, last_rd5;

    // One e strobe: set bus, hold e high for ehigh clocks, drop e, watch the event window
    task automatic strobe(input logic rs, input logic rw, input logic [3:0] nib, input int ehigh);
        int cmd_n = 0, wr_n = 0, cmd_k = 0, wr_k = 0;
        logic [7:0] cb = 0, wc = 0;
        logic [4:0] wi = 0;
        logic busy_at = 0;
        @(negedge clk);
        bus.lcd_rs = rs; bus.lcd_rw = rw;
        {bus.lcd_7, bus.lcd_6, bus.lcd_5, bus.lcd_4} = nib;
        repeat (2) @(negedge clk);
        bus.lcd_e = 1'b1;
        repeat (ehigh) @(negedge clk);
        bus.lcd_e = 1'b0;
        m_strobe(rs, rw, nib, ehigh);
        for (int k = 1; k <= WIN; k++) begin
            @(negedge clk);
            if (bus.cmd_valid) begin
                cmd_n++;
                if (cmd_k == 0) begin cmd_k = k; cb = bus.cmd_byte; busy_at = bus.busy; end
            end
            if (bus.wr_valid) begin
                wr_n++;
                if (wr_k == 0) begin wr_k = k; wi = bus.wr_idx; wc = bus.wr_char; end
            end
            if (k == PULSE_K)     last_rd4 = bus.rd_data;
            if (k == PULSE_K + 1) last_rd5 = bus.rd_data;
        end
        check_eq("cmd_count", 32'(cmd_n), 32'(e_cmd));
        if (e_cmd) begin
            check_eq("cmd_latency", 32'(cmd_k), 32'(PULSE_K));
            check_eq("cmd_byte", 32'(cb), 32'(e_cmd_byte));
            check_eq("busy_with_cmd", 32'(busy_at), 32'(e_clear));
        end
        check_eq("wr_count", 32'(wr_n), 32'(e_wr));
        if (e_wr) begin
            check_eq("wr_latency", 32'(wr_k), 32'(PULSE_K));
            check_eq("wr_idx", 32'(wi), 32'(e_wr_idx));
            check_eq("wr_char", 32'(wc), 32'(e_wr_char));
        end
        check_eq("four_bit", 32'(bus.four_bit), 32'(m_four));
        check_eq("disp_on", 32'(bus.disp_on), 32'(m_disp));
        check_eq("proto_err", 32'(bus.proto_err), 32'(m_err));
        // Wiggle idle pins with e low; must have no effect
        {bus.lcd_rs, bus.lcd_rw, bus.lcd_7, bus.lcd_6, bus.lcd_5, bus.lcd_4} = 6'($urandom);
    endtask

    task automatic send_byte(input logic rs, input logic [7:0] b, input int eh);
        strobe(rs, 1'b0, b[7:4], eh);
        strobe(rs, 1'b0, b[3:0], eh);
    endtask

    task automatic wait_clear();
        int n = 0;
        while (bus.busy && n < 100) begin @(negedge clk); n++; end
        check_eq("busy_drops", 32'(bus.busy), 32'd0);
        @(negedge clk); #1;
        check_eq("busy_len", 32'(last_busy_len), 32'(CLEAR_CYCLES));
        m_busy = 0;
    endtask

    task automatic read_idx(input logic [4:0] idx, output logic [7:0] val);
        @(negedge clk); bus.rd_addr = idx;
        @(negedge clk); val = bus.rd_data;
    endtask

    task automatic check_buf(input string tag);
        logic [7:0] v;
        for (int i = 0; i < 32; i++) begin
            read_idx(5'(i), v);
            check_eq($sformatf("%s[%0d]", tag, i), 32'(v), 32'(m_buf[i]));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        m_reset();
        repeat (3) @(negedge clk);
        check_eq("rst_four_bit", 32'(bus.four_bit), 32'd0);
        check_eq("rst_disp_on", 32'(bus.disp_on), 32'd0);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_proto_err", 32'(bus.proto_err), 32'd0);
        check_eq("rst_cmd_valid", 32'(bus.cmd_valid), 32'd0);
        check_eq("rst_cmd_byte", 32'(bus.cmd_byte), 32'd0);
        check_eq("rst_wr_valid", 32'(bus.wr_valid), 32'd0);
        check_eq("rst_wr_idx", 32'(bus.wr_idx), 32'd0);
        check_eq("rst_wr_char", 32'(bus.wr_char), 32'd0);
        check_eq("rst_rd_data", 32'(bus.rd_data), 32'h20);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic init_seq();
        strobe(1'b0, 1'b0, 4'h3, 14);
        strobe(1'b0, 1'b0, 4'h3, 14);
        strobe(1'b0, 1'b0, 4'h3, 14);
        strobe(1'b0, 1'b0, 4'h2, 14);
    endtask

    function automatic int rand_eh();
        if ($urandom_range(0, 11) == 0) return int'($urandom_range(1, 3));
        return int'($urandom_range(4, 9));
    endfunction

    initial begin
        #800000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] v, old;
        logic [7:0] b;
        logic rs, rw;
        int sel;
        bus.lcd_rs = 0; bus.lcd_rw = 0; bus.lcd_e = 0;
        bus.lcd_4 = 0; bus.lcd_5 = 0; bus.lcd_6 = 0; bus.lcd_7 = 0;
        bus.rd_addr = '0;
        m_reset();
        repeat (2) @(negedge clk);
        do_reset();

        // Power-on init and bring-up instructions
        init_seq();
        check_eq("tp_four_bit", 32'(bus.four_bit), 32'd1);
        send_byte(1'b0, 8'h28, 6);
        send_byte(1'b0, 8'h06, 6);
        send_byte(1'b0, 8'h0C, 6);
        check_eq("tp_disp_on", 32'(bus.disp_on), 32'd1);
        send_byte(1'b0, 8'h01, 6);
        wait_clear();
        check_buf("clr");

        // Data to line 1, then line 2 with same-cycle read/write on idx 16
        send_byte(1'b1, 8'h41, 5);
        send_byte(1'b1, 8'h42, 5);
        send_byte(1'b0, 8'hC0, 5);
        @(negedge clk); bus.rd_addr = 5'd16;
        old = m_buf[16];
        send_byte(1'b1, 8'h5A, 5);
        check_eq("rdw_old", 32'(last_rd4), 32'(old));
        check_eq("rdw_new", 32'(last_rd5), 32'h5A);
        read_idx(5'd0, v);  check_eq("tp_idx0", 32'(v), 32'h41);
        read_idx(5'd1, v);  check_eq("tp_idx1", 32'(v), 32'h42);
        read_idx(5'd16, v); check_eq("tp_idx16", 32'(v), 32'h5A);

        // Out-of-window write at 0x27 then wrap to 0x40
        send_byte(1'b0, 8'hA7, 5);
        send_byte(1'b1, 8'h78, 5);
        send_byte(1'b1, 8'h79, 5);
        read_idx(5'd16, v); check_eq("wrap_idx16", 32'(v), 32'h79);

        // Pulses at and below the e-high threshold
        strobe(1'b0, 1'b0, 4'h0, 1);
        strobe(1'b0, 1'b0, 4'h0, 3);
        strobe(1'b0, 1'b0, 4'h0, 4);
        strobe(1'b0, 1'b0, 4'h8, 4);
        check_eq("short_ignored_err", 32'(bus.proto_err), 32'd0);

        // Decrement mode across the line-2 start
        send_byte(1'b0, 8'h04, 5);
        send_byte(1'b0, 8'hC1, 5);
        send_byte(1'b1, 8'h31, 5);
        send_byte(1'b1, 8'h32, 5);
        send_byte(1'b1, 8'h33, 5);
        send_byte(1'b0, 8'h06, 5);
        check_buf("dec");

        // Randomized traffic
        for (int n = 0; n < 150; n++) begin
            if (!m_four) begin
                sel = int'($urandom_range(0, 7));
                strobe(1'b0, 1'b0, (sel == 0) ? 4'($urandom) : (sel < 4) ? 4'h3 : 4'h2, rand_eh());
            end else begin
                rs = ($urandom_range(0, 9) < 6);
                if (rs) b = 8'($urandom_range(32, 126));
                else begin
                    sel = int'($urandom_range(0, 9));
                    case (sel)
                        0: b = 8'h80 | 8'($urandom_range(0, 15));
                        1: b = 8'hC0 | 8'($urandom_range(0, 15));
                        2: b = 8'h80 | 8'($urandom_range(0, 127));
                        3: b = 8'h04 | 8'($urandom_range(0, 3));
                        4: b = 8'h08 | 8'($urandom_range(0, 7));
                        5: b = 8'h02;
                        6: b = 8'h10 | 8'($urandom_range(0, 15));
                        7: b = 8'h20 | 8'($urandom_range(0, 31));
                        8: b = 8'h40 | 8'($urandom_range(0, 63));
                        default: b = 8'h01;
                    endcase
                end
                for (int h = 0; h < 2; h++) begin
                    rw = ($urandom_range(0, 59) == 0);
                    strobe(rs, rw, (h == 0) ? b[7:4] : b[3:0], rand_eh());
                    if (m_busy) wait_clear();
                end
            end
            if (n % 50 == 49) check_buf("rnd");
        end

        // Read strobe flags an error
        do_reset();
        init_seq();
        strobe(1'b0, 1'b1, 4'h3, 6);
        check_eq("rw_err", 32'(bus.proto_err), 32'd1);

        // Reset between nibbles, then re-init
        do_reset();
        init_seq();
        strobe(1'b0, 1'b0, 4'h0, 6);
        do_reset();
        init_seq();
        send_byte(1'b0, 8'h0C, 6);
        check_eq("post_rst_disp", 32'(bus.disp_on), 32'd1);

        // Strobe during clear is dropped; reset mid-clear restores blank buffer
        send_byte(1'b1, 8'h55, 6);
        send_byte(1'b0, 8'h01, 6);
        strobe(1'b0, 1'b0, 4'h0, 4);
        check_eq("busy_drop_err", 32'(bus.proto_err), 32'd1);
        wait_clear();
        check_buf("clr2");
        send_byte(1'b1, 8'h66, 6);
        send_byte(1'b1, 8'h67, 6);
        send_byte(1'b0, 8'h01, 6);
        do_reset();
        check_buf("rstclr");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/lcd_rx_monitor.md
# lcd_rx_monitor

Receive-side model of the 4-bit HD44780-style character LCD bus driven by the team's LCD writer. It samples `lcd_rs`/`lcd_rw`/`lcd_e`/`lcd_7..lcd_4`, reassembles nibbles into bytes, and tracks the power-on 8-bit/4-bit mode switch. It decodes instructions and keeps a 2x16 display-RAM mirror that the rest of the design (or a testbench) can read back. It sits on the FPGA side as a loopback checker for the LCD path and as a software-visible shadow of the panel contents.

## Interface
- `MIN_E_HIGH`, default 4: minimum synchronized `lcd_e` high time, in clocks, for a strobe to count.
- `CLEAR_CYCLES`, default 32: busy duration of a clear instruction; one buffer entry is cleared per cycle.

- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `lcd_rs`, `lcd_rw`, `lcd_e`, `lcd_4`, `lcd_5`, `lcd_6`, `lcd_7` in 1 each: LCD bus, asynchronous to `clk`.
- `rd_addr` in 5: buffer read index. Indices 0–15 are line 1 and 16–31 are line 2.
- `rd_data` out 8: buffer byte at `rd_addr`, registered.
- `cmd_valid` out 1: one-cycle pulse when an instruction byte (rs=0) completes.
- `cmd_byte` out 8: the completed instruction byte, valid while `cmd_valid` is high.
- `wr_valid` out 1: one-cycle pulse when a data byte lands in the buffer.
- `wr_idx` out 5, `wr_char` out 8: index and character of the write reported by `wr_valid`.
- `four_bit` out 1: high when the bus is in 4-bit nibble mode.
- `disp_on` out 1: display-on bit (D) from the last display-control instruction.
- `busy` out 1: high while a clear is in progress.
- `proto_err` out 1: sticky protocol-error flag, cleared only by reset.

## Operation
- All bus inputs pass through a 2-flop synchronizer. A strobe is a falling edge of synchronized `e` after at least `MIN_E_HIGH` high cycles. The high counter saturates. Shorter pulses are ignored silently.
- On a strobe, the nibble is `{lcd_7,lcd_6,lcd_5,lcd_4}` and rs comes from the synchronized samples in the same cycle.
- A strobe with rw=1 is dropped and sets `proto_err`; reads are unsupported.
- Mode FSM states are INIT8, HI and LO. The reset state is INIT8.
  - INIT8: each strobe is a complete 8-bit-mode function set carrying the upper nibble only. Nibble 0x3 stays in INIT8. Nibble 0x2 moves to HI and sets `four_bit`=1. Any other nibble sets `proto_err` and stays in INIT8.
  - HI: latch the high nibble and rs, then go to LO.
  - LO: form the byte and go to HI. The rs value latched in HI is used; if the LO rs differs, set `proto_err`.
- Instruction decode for rs=0, priority from the top bit down:
  - 1xxxxxxx: DDRAM address is set to `byte[6:0]`; CGRAM-select is cleared.
  - 01xxxxxx: CGRAM-select is set. Subsequent data writes are dropped.
  - 001xxxxx (function set): if DL, bit 4, is 1, go to INIT8 and clear `four_bit`.
  - 0001xxxx: cursor/display shift; ignored.
  - 00001xxx: `disp_on` is set to bit 2.
  - 000001xx: entry mode; the ID flag is set to bit 1.
  - 0000001x: return home; address is set to 0.
  - 00000001: clear. Address is set to 0, ID is set to 1, and `busy` is asserted. The buffer is written with 0x20 at indices 0..31, one per cycle. `busy` then drops.
- Every completed rs=0 byte pulses `cmd_valid`, including ignored instructions.
- Data byte handling (rs=1):
  - Address window mapping: 0x00–0x0F maps to index 0–15, and 0x40–0x4F maps to index 16–31.
  - An in-window write with CGRAM-select clear writes the buffer and pulses `wr_valid`.
  - Out-of-window and CGRAM writes are dropped with no pulse.
  - The address moves after every data byte, whether or not the byte was dropped. With ID=1 it increments; with ID=0 it decrements.
  - Increment wraps 0x27→0x40 and 0x67→0x00. Decrement wraps 0x00→0x67 and 0x40→0x27.
- A strobe that completes while `busy`=1 is dropped and sets `proto_err`. The FSM does not advance.
- Reset, including mid-byte or mid-clear, returns to:
  - state INIT8, `four_bit`=0, `disp_on`=0, `busy`=0, `proto_err`=0;
  - address 0, ID=1, CGRAM-select=0;
  - every buffer byte 0x20, `rd_data`=0x20;
  - `cmd_valid`=0, `wr_valid`=0, `cmd_byte`=0, `wr_idx`=0, `wr_char`=0.

## Timing
- Let edge N be the first `clk` edge that samples raw `lcd_e` low after a qualifying high. The strobe is recognised at edge N+2.
- `cmd_valid` or `wr_valid` is high for exactly the cycle after edge N+3. The buffer write and the `four_bit`/`disp_on`/address updates are visible from the same cycle.
- Bus setup and hold requirement: `rs`, `rw` and data stable from 2 clocks before `e` falls until 3 clocks after.
- `busy` rises in the same cycle as the clear's `cmd_valid` and stays high exactly `CLEAR_CYCLES` cycles.
- `rd_data` has 1-cycle latency from `rd_addr`. A read and a write to the same index in the same cycle return the old value.

## Test plan
- Drive nibbles 0x3, 0x3, 0x3, 0x2 (e high 14 clocks) → `four_bit`=1 after the fourth strobe, no `cmd_valid`, `proto_err`=0.
- Continue with bytes 0x28, 0x06, 0x0C, 0x01:
  - → four `cmd_valid` pulses with matching `cmd_byte`;
  - → `disp_on`=1;
  - → `busy` high for 32 cycles, after which every index reads 0x20.
- Data "A", "B", then instruction 0xC0, then data "Z" → `wr_valid` ×3; idx0=0x41, idx1=0x42, idx16=0x5A.
- Instruction 0xA7, then data ×2:
  - → first write dropped (address 0x27 is out of window), then the address wraps to 0x40;
  - → second byte lands at idx16 with `wr_valid`.
- A 1-clock `e` pulse → ignored, FSM unchanged. A strobe with rw=1 → `proto_err`=1.
- Assert `rst_n` low between the high and low nibble → state INIT8, all outputs at reset values, and the next 0x3/0x2 init sequence works.
